fu_issue_scheduler: RTL and testbench
=====================================

Name: fu_issue_scheduler

Overview:
- Sequences per-cycle issue from the RS issue slots into the 3 ALUs and the single pipelined multiplier.
- Tracks in-flight multiplies with their branch masks and reserves CDB writeback slots, so ALU grants never oversubscribe the CDB in the cycle a multiply completes.
- Sits between RS select logic and FU allocation; its grant vector gates which RS outputs are presented as valid.

Parameters:
- NUM_REQ, 3, number of RS issue candidates per cycle
- CDB_WIDTH, 3, writeback broadcasts per cycle
- MULT_LAT, 4, multiplier latency in cycles (>=2)
- BS, `BRANCH_STACK_SIZE, branch mask width

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  candidate i is ready to issue
- req_is_mult  in  NUM_REQ  candidate i is a multiply
- req_branch_mask  in  NUM_REQ*BS  branch mask of candidate i, in slice [i*BS +: BS]
- branch_recovery  in  1  mispredict resolved this cycle
- branch_correct  in  1  correct prediction resolved this cycle
- branch_stack  in  BS  one-hot tag of the resolving branch
- grant  out  NUM_REQ  candidate i issues this cycle
- mult_wb_valid  out  1  a surviving multiply writes back this cycle
- mult_wb_mask  out  BS  branch mask of the writing-back multiply
- mult_inflight  out  MULT_LAT  per-stage valid bits of the multiply pipe
- mult_count  out  $clog2(MULT_LAT+1)  number of valid multiply-pipe entries

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- State: multiply pipe of MULT_LAT entries {valid, mask[BS]}, with stage 0 as the youngest.
- Reset values: all pipe entries invalid with masks 0. While reset_n=0, every output is forced 0, including grant.
- Squash test, per candidate: kill_i = branch_recovery & |(req_branch_mask_i & branch_stack). A killed candidate is never granted and consumes no slot.
- Multiply grant:
  - Grant the lowest-index candidate with req_valid & req_is_mult & !kill.
  - Every other multiply candidate gets grant=0 this cycle.
  - At most one multiply is granted per cycle; there is no structural multiply stall.
- CDB reservation:
  - mult_next = pipe[MULT_LAT-2].valid & !(branch_recovery & |(pipe[MULT_LAT-2].mask & branch_stack)).
  - ALU slots = CDB_WIDTH - mult_next.
- ALU grant:
  - Scan non-multiply, non-killed valid candidates from index 0 upward.
  - Grant until the slot count is exhausted; remaining candidates get 0.
  - Grant is combinational from inputs and registered state.
- Pipe update at posedge:
  - pipe[k+1] <= pipe[k] for each stage.
  - pipe[0] <= granted multiply {1, mask}, or invalid if no multiply is granted.
  - The final stage drops out.
- Recovery: if branch_recovery is high, every pipe entry (including the incoming one) whose mask overlaps branch_stack is written invalid.
- Branch correct:
  - If branch_correct is high and branch_recovery is low, mask bits selected by branch_stack are cleared in every stored entry and in the incoming entry.
  - If both are asserted, recovery takes precedence and no bits are cleared.
- Writeback outputs: mult_wb_valid = pipe[MULT_LAT-1].valid and mult_wb_mask = its mask. Both are registered.
  - A multiply granted in cycle t asserts mult_wb_valid in cycle t+MULT_LAT.
  - An ALU op granted in cycle t writes back in cycle t+1.
- Same-cycle squash of a completing multiply: if pipe[MULT_LAT-1] is squashed by a recovery in that same cycle, mult_wb_valid is still shown as 1. FU allocation applies its own squash; the CDB slot was already reserved.
- mult_count is the popcount of the registered valid bits.
- Reset mid-operation: all in-flight multiplies are discarded immediately, with no writeback.

Test Plan:
- Reset, then req_valid=3'b111, req_is_mult=0 → grant=3'b111; mult_count=0; mult_wb_valid=0.
- Multiply on slot 0 at cycle 0, then three ALU requests every cycle:
  - Cycles 0-2: grant=3'b111 each cycle (multiply plus two ALUs at cycle 0).
  - Cycle 3: grant=3'b011 (mult_next=1).
  - Cycle 4: mult_wb_valid=1.
- req_is_mult=3'b101, all valid → grant=3'b011: slot 0 multiply plus slot 1 ALU; slot 2 multiply deferred.
- Multiply with mask 4'b0010 in flight at stage 1; branch_recovery=1, branch_stack=4'b0010 → entry invalidated; mult_count drops by 1; no mult_wb_valid; the ALU slot is not reserved in the cycle it would have completed.
- Multiply with mask 4'b0110; branch_correct=1, branch_stack=4'b0100 → mult_wb_mask=4'b0010 at writeback.
- Candidate with mask 4'b1000 during branch_recovery with branch_stack=4'b1000 → grant bit 0. Deassert reset_n while 3 multiplies are in flight → mult_inflight=0 asynchronously; no writeback after release.

Source files
------------

// File: rtl/fu_issue_scheduler_if.sv
// Issue-scheduler bus: RS candidates and branch resolution in, grants and
// multiply-pipe status out. master = RS/branch side, slave = scheduler.
`ifndef BRANCH_STACK_SIZE
`define BRANCH_STACK_SIZE 4
`endif

interface fu_issue_scheduler_if #(
    parameter int NUM_REQ  = 3,
    parameter int MULT_LAT = 4,
    parameter int BS       = `BRANCH_STACK_SIZE
);
    localparam int CNT_W = $clog2(MULT_LAT + 1);

    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_is_mult;
    logic [NUM_REQ*BS-1:0] req_branch_mask;
    logic                  branch_recovery;
    logic                  branch_correct;
    logic [BS-1:0]         branch_stack;

    logic [NUM_REQ-1:0]    grant;
    logic                  mult_wb_valid;
    logic [BS-1:0]         mult_wb_mask;
    logic [MULT_LAT-1:0]   mult_inflight;
    logic [CNT_W-1:0]      mult_count;

    modport master (
        output req_valid, req_is_mult, req_branch_mask,
        output branch_recovery, branch_correct, branch_stack,
        input  grant, mult_wb_valid, mult_wb_mask, mult_inflight, mult_count
    );

    modport slave (
        input  req_valid, req_is_mult, req_branch_mask,
        input  branch_recovery, branch_correct, branch_stack,
        output grant, mult_wb_valid, mult_wb_mask, mult_inflight, mult_count
    );
endinterface

// File: rtl/fu_issue_scheduler.sv
// Per-cycle issue arbiter for 3 ALUs and one pipelined multiplier. Tracks
// in-flight multiplies with their branch masks and holds back one ALU grant
// in the cycle before a multiply writes back, so the CDB is never
// oversubscribed.
`ifndef BRANCH_STACK_SIZE
`define BRANCH_STACK_SIZE 4
`endif

module fu_issue_scheduler #(
    parameter int NUM_REQ   = 3,
    parameter int CDB_WIDTH = 3,
    parameter int MULT_LAT  = 4,
    parameter int BS        = `BRANCH_STACK_SIZE
) (
    input  logic                 clock,
    input  logic                 reset_n,
    fu_issue_scheduler_if.slave  bus
);
    localparam int CNT_W = $clog2(MULT_LAT + 1);

    logic [MULT_LAT-1:0]          pipe_valid;
    logic [MULT_LAT-1:0]          pipe_valid_n;
    logic [MULT_LAT-1:0][BS-1:0]  pipe_mask;
    logic [MULT_LAT-1:0][BS-1:0]  pipe_mask_n;

    logic [NUM_REQ-1:0] kill;
    logic [NUM_REQ-1:0] mult_sel;
    logic [NUM_REQ-1:0] alu_sel;
    logic               in_valid;
    logic [BS-1:0]      in_mask;
    logic               mult_next;
    logic               clear_en;
    int                 alu_slots;
    int                 alu_used;

    // Candidates younger than a mispredicted branch are dropped before arbitration
    always_comb begin
        kill = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            kill[i] = bus.branch_recovery
                    & (|(bus.req_branch_mask[i*BS +: BS] & bus.branch_stack));
        end
    end

    // Lowest-index surviving multiply wins the single multiplier issue port
    always_comb begin
        mult_sel = '0;
        in_valid = 1'b0;
        in_mask  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!in_valid && bus.req_valid[i] && bus.req_is_mult[i] && !kill[i]) begin
                mult_sel[i] = 1'b1;
                in_valid    = 1'b1;
                in_mask     = bus.req_branch_mask[i*BS +: BS];
            end
        end
    end

    // A multiply about to enter the last stage owns one CDB slot next cycle,
    // unless the branch resolving now squashes it.
    assign mult_next = pipe_valid[MULT_LAT-2]
                     & ~(bus.branch_recovery & (|(pipe_mask[MULT_LAT-2] & bus.branch_stack)));

    // ALU grants fill the remaining CDB slots in index order
    always_comb begin
        alu_sel   = '0;
        alu_used  = 0;
        alu_slots = CDB_WIDTH - (mult_next ? 1 : 0);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.req_valid[i] && !bus.req_is_mult[i] && !kill[i] && (alu_used < alu_slots)) begin
                alu_sel[i] = 1'b1;
                alu_used   = alu_used + 1;
            end
        end
    end

    // Grant is held low throughout reset so nothing issues from stale RS state
    assign bus.grant = reset_n ? (mult_sel | alu_sel) : '0;

    assign clear_en = bus.branch_correct & ~bus.branch_recovery;

    // Shift the pipe, then apply squash (recovery) or mask clearing (correct)
    // to every entry including the one entering stage 0.
    always_comb begin
        pipe_valid_n    = '0;
        pipe_mask_n     = '0;
        pipe_valid_n[0] = in_valid;
        pipe_mask_n[0]  = in_mask;
        for (int k = 1; k < MULT_LAT; k++) begin
            pipe_valid_n[k] = pipe_valid[k-1];
            pipe_mask_n[k]  = pipe_mask[k-1];
        end
        for (int k = 0; k < MULT_LAT; k++) begin
            if (bus.branch_recovery && (|(pipe_mask_n[k] & bus.branch_stack))) begin
                pipe_valid_n[k] = 1'b0;
                pipe_mask_n[k]  = '0;
            end else if (clear_en) begin
                pipe_mask_n[k] = pipe_mask_n[k] & ~bus.branch_stack;
            end
        end
    end

    // Multiply pipe state; reset discards every in-flight entry at once
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_valid <= '0;
            pipe_mask  <= '0;
        end else begin
            pipe_valid <= pipe_valid_n;
            pipe_mask  <= pipe_mask_n;
        end
    end

    // The last stage is shown as-is: a same-cycle squash is left to FU
    // allocation since the CDB slot is already reserved.
    assign bus.mult_wb_valid = pipe_valid[MULT_LAT-1];
    assign bus.mult_wb_mask  = pipe_mask[MULT_LAT-1];
    assign bus.mult_inflight = pipe_valid;
    assign bus.mult_count    = CNT_W'($countones(pipe_valid));

endmodule

// File: tb/tb_fu_issue_scheduler.sv
// Directed bench for fu_issue_scheduler. Stimulus pushes the hand-computed
// response for each cycle into a queue; a negedge monitor pops and compares.
module tb_fu_issue_scheduler;

    logic clock;
    logic reset_n;

    fu_issue_scheduler_if #(.NUM_REQ(3), .MULT_LAT(4), .BS(4)) bus ();

    fu_issue_scheduler #(.NUM_REQ(3), .CDB_WIDTH(3), .MULT_LAT(4), .BS(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [2:0] g;
        logic       wv;
        logic [3:0] wm;
        logic [2:0] cnt;
        logic [3:0] inf;
        logic [4:0] chk;   // {inflight, count, wb_mask, wb_valid, grant}
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   total = 0;
    int   bad   = 0;

    localparam logic [4:0] ALL = 5'b11111;
    localparam logic [4:0] NOM = 5'b11011;
    localparam logic [4:0] NON = 5'b00000;

    task automatic cmp(input string nm, input string fld, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            if (cur.chk[0]) cmp(cur.name, "grant",    {1'b0, bus.grant},         {1'b0, cur.g});
            if (cur.chk[1]) cmp(cur.name, "wb_valid", {3'b0, bus.mult_wb_valid}, {3'b0, cur.wv});
            if (cur.chk[2]) cmp(cur.name, "wb_mask",  bus.mult_wb_mask,          cur.wm);
            if (cur.chk[3]) cmp(cur.name, "count",    {1'b0, bus.mult_count},    {1'b0, cur.cnt});
            if (cur.chk[4]) cmp(cur.name, "inflight", bus.mult_inflight,         cur.inf);
        end
    end

    task automatic drive(input logic [2:0] v, input logic [2:0] m, input logic [11:0] bm,
                         input logic rec, input logic corr, input logic [3:0] st);
        bus.req_valid       = v;
        bus.req_is_mult     = m;
        bus.req_branch_mask = bm;
        bus.branch_recovery = rec;
        bus.branch_correct  = corr;
        bus.branch_stack    = st;
    endtask

    task automatic push(input string nm, input logic [2:0] g, input logic wv, input logic [3:0] wm,
                        input logic [2:0] cnt, input logic [3:0] inf, input logic [4:0] chk);
        exp_t e;
        e.name = nm; e.g = g; e.wv = wv; e.wm = wm; e.cnt = cnt; e.inf = inf; e.chk = chk;
        exp_q.push_back(e);
    endtask

    task automatic step(input string nm, input logic [2:0] v, input logic [2:0] m, input logic [11:0] bm,
                        input logic rec, input logic corr, input logic [3:0] st,
                        input logic [2:0] g, input logic wv, input logic [3:0] wm,
                        input logic [2:0] cnt, input logic [3:0] inf, input logic [4:0] chk);
        drive(v, m, bm, rec, corr, st);
        push(nm, g, wv, wm, cnt, inf, chk);
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step("drain", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 3'd0, 4'h0, NON);
    endtask

    initial begin
        reset_n = 1'b0;
        drive(3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0);
        @(posedge clock);
        #1;

        // grant forced low while in reset
        step("rst_hold", 3'b111, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 3'd0, 4'h0, ALL);
        reset_n = 1'b1;
        step("alu3",     3'b111, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b111, 1'b0, 4'h0, 3'd0, 4'h0, NOM);

        // multiply at cycle 0, ALU traffic after; CDB reserved at cycle 3
        step("mul_c0", 3'b111, 3'b001, 12'h000, 1'b0, 1'b0, 4'h0, 3'b111, 1'b0, 4'h0, 3'd0, 4'b0000, NOM);
        step("mul_c1", 3'b111, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b111, 1'b0, 4'h0, 3'd1, 4'b0001, NOM);
        step("mul_c2", 3'b111, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b111, 1'b0, 4'h0, 3'd1, 4'b0010, NOM);
        step("mul_c3", 3'b111, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b011, 1'b0, 4'h0, 3'd1, 4'b0100, NOM);
        step("mul_c4", 3'b111, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b111, 1'b1, 4'h0, 3'd1, 4'b1000, ALL);
        step("mul_c5", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 3'd0, 4'b0000, NOM);

        // two multiply candidates: only the lowest issues
        step("two_mul0", 3'b111, 3'b101, 12'h000, 1'b0, 1'b0, 4'h0, 3'b011, 1'b0, 4'h0, 3'd0, 4'b0000, NOM);
        step("two_mul1", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 3'd1, 4'b0001, NOM);
        idle(4);

        // recovery squashes A (mask 0010) at stage 1, B (mask 0001) survives
        step("rec_r0", 3'b001, 3'b001, 12'h002, 1'b0, 1'b0, 4'h0,    3'b001, 1'b0, 4'h0, 3'd0, 4'b0000, NOM);
        step("rec_r1", 3'b010, 3'b010, 12'h010, 1'b0, 1'b0, 4'h0,    3'b010, 1'b0, 4'h0, 3'd1, 4'b0001, NOM);
        step("rec_r2", 3'b000, 3'b000, 12'h000, 1'b1, 1'b0, 4'b0010, 3'b000, 1'b0, 4'h0, 3'd2, 4'b0011, NOM);
        step("rec_r3", 3'b111, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0,    3'b111, 1'b0, 4'h0, 3'd1, 4'b0010, NOM);
        step("rec_r4", 3'b111, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0,    3'b011, 1'b0, 4'h0, 3'd1, 4'b0100, NOM);
        step("rec_r5", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0,    3'b000, 1'b1, 4'b0001, 3'd1, 4'b1000, ALL);
        step("rec_r6", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0,    3'b000, 1'b0, 4'h0, 3'd0, 4'b0000, NOM);

        // branch correct clears bit 2 in a stored entry and in the incoming one
        step("cor_c0", 3'b001, 3'b001, 12'h006, 1'b0, 1'b0, 4'h0,    3'b001, 1'b0, 4'h0,    3'd0, 4'b0000, NOM);
        step("cor_c1", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0,    3'b000, 1'b0, 4'h0,    3'd1, 4'b0001, NOM);
        step("cor_c2", 3'b001, 3'b001, 12'h00C, 1'b0, 1'b1, 4'b0100, 3'b001, 1'b0, 4'h0,    3'd1, 4'b0010, NOM);
        step("cor_c3", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0,    3'b000, 1'b0, 4'h0,    3'd2, 4'b0101, NOM);
        step("cor_c4", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0,    3'b000, 1'b1, 4'b0010, 3'd2, 4'b1010, ALL);
        step("cor_c5", 3'b111, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0,    3'b011, 1'b0, 4'h0,    3'd1, 4'b0100, NOM);
        step("cor_c6", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0,    3'b000, 1'b1, 4'b1000, 3'd1, 4'b1000, ALL);
        step("cor_c7", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0,    3'b000, 1'b0, 4'h0,    3'd0, 4'b0000, NOM);

        // killed candidates: ALU on slot 0, then killed multiply lets slot 2 issue
        step("kill_k0", 3'b111, 3'b000, 12'h008, 1'b1, 1'b0, 4'b1000, 3'b110, 1'b0, 4'h0, 3'd0, 4'b0000, NOM);
        step("kill_k1", 3'b111, 3'b101, 12'h008, 1'b1, 1'b0, 4'b1000, 3'b110, 1'b0, 4'h0, 3'd0, 4'b0000, NOM);
        step("kill_k2", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0,    3'b000, 1'b0, 4'h0, 3'd1, 4'b0001, NOM);
        idle(4);

        // reset with three multiplies in flight
        step("rst_a0", 3'b001, 3'b001, 12'h000, 1'b0, 1'b0, 4'h0, 3'b001, 1'b0, 4'h0, 3'd0, 4'b0000, NOM);
        step("rst_a1", 3'b001, 3'b001, 12'h000, 1'b0, 1'b0, 4'h0, 3'b001, 1'b0, 4'h0, 3'd1, 4'b0001, NOM);
        step("rst_a2", 3'b001, 3'b001, 12'h000, 1'b0, 1'b0, 4'h0, 3'b001, 1'b0, 4'h0, 3'd2, 4'b0011, NOM);
        step("rst_a3", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 3'd3, 4'b0111, NOM);
        drive(3'b111, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0);
        #1;
        reset_n = 1'b0;
        push("rst_a4", 3'b000, 1'b0, 4'h0, 3'd0, 4'b0000, ALL);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        step("rst_a5", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 3'd0, 4'b0000, ALL);
        step("rst_a6", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 3'd0, 4'b0000, ALL);
        step("rst_a7", 3'b000, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b000, 1'b0, 4'h0, 3'd0, 4'b0000, ALL);
        step("rst_a8", 3'b111, 3'b000, 12'h000, 1'b0, 1'b0, 4'h0, 3'b111, 1'b0, 4'h0, 3'd0, 4'b0000, NOM);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
